// File: rtl/id_stage_pipe.sv
// -----------------------------------------------------------------------------
// id_stage_pipe
//   Instruction decode stage with a registered ID/EX output. Decodes the logic,
//   logic-immediate, LUI and shift instructions, forwards operands from the EX
//   and MEM stages, and holds the instruction upstream on a load-use hazard.
//   Valid/ready handshake on both the input and the output side.
//
// Ports
//   clk, rst                    clock (rising edge), synchronous active-high reset
//   in_valid / in_ready         upstream handshake for pc_i / inst_i
//   pc_i, inst_i                instruction PC and instruction word
//   flush_i                     kill the held and the incoming instruction
//   reg{1,2}_read_o/_addr_o     regfile read enables / addresses (combinational)
//   reg{1,2}_data_i             regfile read data
//   ex_*                        EX-stage write-back info (incl. load flag)
//   mem_*                       MEM-stage write-back info
//   stallreq_o                  load-use hazard (combinational)
//   out_valid / out_ready       downstream handshake for the ID/EX register
//   pc_o .. inst_invalid_o      ID/EX register contents
// -----------------------------------------------------------------------------
module id_stage_pipe #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int RA_W   = 5,
    parameter bit FWD_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic [31:0]       inst_i,
    input  logic              flush_i,
    output logic              reg1_read_o,
    output logic [RA_W-1:0]   reg1_addr_o,
    input  logic [DATA_W-1:0] reg1_data_i,
    output logic              reg2_read_o,
    output logic [RA_W-1:0]   reg2_addr_o,
    input  logic [DATA_W-1:0] reg2_data_i,
    input  logic              ex_wreg_i,
    input  logic [RA_W-1:0]   ex_wd_i,
    input  logic [DATA_W-1:0] ex_wdata_i,
    input  logic              ex_is_load_i,
    input  logic              mem_wreg_i,
    input  logic [RA_W-1:0]   mem_wd_i,
    input  logic [DATA_W-1:0] mem_wdata_i,
    output logic              stallreq_o,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] pc_o,
    output logic [7:0]        aluop_o,
    output logic [2:0]        alusel_o,
    output logic [DATA_W-1:0] reg1_o,
    output logic [DATA_W-1:0] reg2_o,
    output logic [RA_W-1:0]   wd_o,
    output logic              wreg_o,
    output logic              inst_invalid_o
);

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_ANDI    = 6'h0C;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] OP_XORI    = 6'h0E;
    localparam logic [5:0] OP_LUI     = 6'h0F;

    localparam logic [2:0] SEL_NOP    = 3'b000;
    localparam logic [2:0] SEL_LOGIC  = 3'b001;
    localparam logic [2:0] SEL_SHIFT  = 3'b010;

    // Operand mux for one read port. A port that is not read carries the
    // immediate / shift amount. $0 always reads as zero, even if a younger
    // stage claims to write it.
    function automatic logic [DATA_W-1:0] pick_operand(
        input logic              re,
        input logic [RA_W-1:0]   addr,
        input logic [DATA_W-1:0] rf_data,
        input logic [DATA_W-1:0] imm,
        input logic              ex_we,
        input logic [RA_W-1:0]   ex_wa,
        input logic [DATA_W-1:0] ex_data,
        input logic              mem_we,
        input logic [RA_W-1:0]   mem_wa,
        input logic [DATA_W-1:0] mem_data
    );
        logic [DATA_W-1:0] val;
        if (!re)
            val = imm;
        else if (addr == '0)
            val = '0;
        else if (FWD_EN && ex_we && ex_wa == addr)
            val = ex_data;
        else if (FWD_EN && mem_we && mem_wa == addr)
            val = mem_data;
        else
            val = rf_data;
        return val;
    endfunction

    logic [5:0]        op, func;
    logic [4:0]        sa;
    logic [RA_W-1:0]   rs, rt, rd;
    logic [15:0]       imm16;

    logic [7:0]        dec_aluop;
    logic [2:0]        dec_sel;
    logic              dec_re1, dec_re2, dec_wreg, dec_inv;
    logic [RA_W-1:0]   dec_wd;
    logic [DATA_W-1:0] dec_imm, src1, src2;
    logic              re1, re2, transfer;

    assign op    = inst_i[31:26];
    assign rs    = RA_W'(inst_i[25:21]);
    assign rt    = RA_W'(inst_i[20:16]);
    assign rd    = RA_W'(inst_i[15:11]);
    assign sa    = inst_i[10:6];
    assign func  = inst_i[5:0];
    assign imm16 = inst_i[15:0];

    always_comb begin
        dec_aluop = 8'h00;
        dec_sel   = SEL_NOP;
        dec_re1   = 1'b0;
        dec_re2   = 1'b0;
        dec_wd    = '0;
        dec_wreg  = 1'b0;
        dec_inv   = 1'b1;
        dec_imm   = '0;
        case (op)
            OP_ORI, OP_ANDI, OP_XORI, OP_LUI: begin
                dec_sel  = SEL_LOGIC;
                dec_re1  = 1'b1;
                dec_wd   = rt;
                dec_wreg = 1'b1;
                dec_inv  = 1'b0;
                case (op)
                    OP_ANDI: dec_aluop = 8'h24;
                    OP_XORI: dec_aluop = 8'h26;
                    default: dec_aluop = 8'h25;
                endcase
                // LUI is executed as OR of $0 with the shifted immediate
                dec_imm = (op == OP_LUI) ? DATA_W'({imm16, 16'h0000}) : DATA_W'(imm16);
            end
            OP_SPECIAL: begin
                if (sa == 5'd0 && (func == 6'h24 || func == 6'h25 ||
                                   func == 6'h26 || func == 6'h27)) begin
                    dec_aluop = {2'b00, func};
                    dec_sel   = SEL_LOGIC;
                    dec_re1   = 1'b1;
                    dec_re2   = 1'b1;
                    dec_wd    = rd;
                    dec_wreg  = 1'b1;
                    dec_inv   = 1'b0;
                end else if (rs == '0 && (func == 6'h00 || func == 6'h02 ||
                                          func == 6'h03)) begin
                    dec_aluop = (func == 6'h00) ? 8'h7C : {2'b00, func};
                    dec_sel   = SEL_SHIFT;
                    dec_re2   = 1'b1;
                    dec_wd    = rd;
                    dec_wreg  = 1'b1;
                    dec_inv   = 1'b0;
                    dec_imm   = DATA_W'(sa);
                end
            end
            default: ;
        endcase
    end

    // Read ports are silenced while in reset
    assign re1         = dec_re1 & ~rst;
    assign re2         = dec_re2 & ~rst;
    assign reg1_read_o = re1;
    assign reg2_read_o = re2;
    assign reg1_addr_o = rst ? '0 : rs;
    assign reg2_addr_o = rst ? '0 : rt;

    assign src1 = pick_operand(re1, rs, reg1_data_i, dec_imm, ex_wreg_i, ex_wd_i, ex_wdata_i,
                               mem_wreg_i, mem_wd_i, mem_wdata_i);
    assign src2 = pick_operand(re2, rt, reg2_data_i, dec_imm, ex_wreg_i, ex_wd_i, ex_wdata_i,
                               mem_wreg_i, mem_wd_i, mem_wdata_i);

    // A load in EX cannot be forwarded yet; hold the consumer upstream
    assign stallreq_o = in_valid & ex_is_load_i & ex_wreg_i & (ex_wd_i != '0) &
                        ((re1 & (ex_wd_i == rs)) | (re2 & (ex_wd_i == rt)));

    assign in_ready = ~rst & (~out_valid | out_ready) & ~stallreq_o;
    assign transfer = in_valid & in_ready & ~flush_i;

    // ---- stage boundary: ID -> ID/EX register ----
    logic              vld_p1;
    logic [ADDR_W-1:0] pc_p1;
    logic [7:0]        aluop_p1;
    logic [2:0]        alusel_p1;
    logic [DATA_W-1:0] reg1_p1, reg2_p1;
    logic [RA_W-1:0]   wd_p1;
    logic              wreg_p1, inv_p1;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1    <= 1'b0;
            pc_p1     <= '0;
            aluop_p1  <= '0;
            alusel_p1 <= '0;
            reg1_p1   <= '0;
            reg2_p1   <= '0;
            wd_p1     <= '0;
            wreg_p1   <= 1'b0;
            inv_p1    <= 1'b0;
        end else if (flush_i) begin
            vld_p1    <= 1'b0;
        end else if (transfer) begin
            vld_p1    <= 1'b1;
            pc_p1     <= pc_i;
            aluop_p1  <= dec_aluop;
            alusel_p1 <= dec_sel;
            reg1_p1   <= src1;
            reg2_p1   <= src2;
            wd_p1     <= dec_wd;
            wreg_p1   <= dec_wreg;
            inv_p1    <= dec_inv;
        end else if (vld_p1 && out_ready) begin
            vld_p1    <= 1'b0;
        end
    end

    assign out_valid      = vld_p1;
    assign pc_o           = pc_p1;
    assign aluop_o        = aluop_p1;
    assign alusel_o       = alusel_p1;
    assign reg1_o         = reg1_p1;
    assign reg2_o         = reg2_p1;
    assign wd_o           = wd_p1;
    assign wreg_o         = wreg_p1;
    assign inst_invalid_o = inv_p1;

endmodule

// File: tb/tb_id_stage_pipe.sv
// -----------------------------------------------------------------------------
// tb_id_stage_pipe
//   Scoreboard bench for id_stage_pipe. Two instances share all inputs: one
//   with forwarding enabled and one with forwarding disabled. Stimulus pushes
//   the hand-computed expected ID/EX contents; a monitor pops and compares
//   whenever the output handshake completes.
// -----------------------------------------------------------------------------
module tb_id_stage_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, flush_i, out_ready;
    logic [31:0] pc_i, inst_i;
    logic [31:0] reg1_data_i, reg2_data_i, ex_wdata_i, mem_wdata_i;
    logic [4:0]  ex_wd_i, mem_wd_i;
    logic        ex_wreg_i, ex_is_load_i, mem_wreg_i;

    logic        in_ready, reg1_read_o, reg2_read_o, stallreq_o, out_valid, wreg_o, inst_invalid_o;
    logic [4:0]  reg1_addr_o, reg2_addr_o, wd_o;
    logic [31:0] pc_o, reg1_o, reg2_o;
    logic [7:0]  aluop_o;
    logic [2:0]  alusel_o;

    logic        in_ready_nf, reg1_read_nf, reg2_read_nf, stallreq_nf, out_valid_nf, wreg_nf, inv_nf;
    logic [4:0]  reg1_addr_nf, reg2_addr_nf, wd_nf;
    logic [31:0] pc_nf, reg1_nf, reg2_nf;
    logic [7:0]  aluop_nf;
    logic [2:0]  alusel_nf;

    always #5 clk = ~clk;

    id_stage_pipe #(.DATA_W(32), .ADDR_W(32), .RA_W(5), .FWD_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .pc_i(pc_i), .inst_i(inst_i), .flush_i(flush_i),
        .reg1_read_o(reg1_read_o), .reg1_addr_o(reg1_addr_o), .reg1_data_i(reg1_data_i),
        .reg2_read_o(reg2_read_o), .reg2_addr_o(reg2_addr_o), .reg2_data_i(reg2_data_i),
        .ex_wreg_i(ex_wreg_i), .ex_wd_i(ex_wd_i), .ex_wdata_i(ex_wdata_i), .ex_is_load_i(ex_is_load_i),
        .mem_wreg_i(mem_wreg_i), .mem_wd_i(mem_wd_i), .mem_wdata_i(mem_wdata_i),
        .stallreq_o(stallreq_o), .out_valid(out_valid), .out_ready(out_ready),
        .pc_o(pc_o), .aluop_o(aluop_o), .alusel_o(alusel_o), .reg1_o(reg1_o), .reg2_o(reg2_o),
        .wd_o(wd_o), .wreg_o(wreg_o), .inst_invalid_o(inst_invalid_o)
    );

    id_stage_pipe #(.DATA_W(32), .ADDR_W(32), .RA_W(5), .FWD_EN(1'b0)) dut_nf (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_nf),
        .pc_i(pc_i), .inst_i(inst_i), .flush_i(flush_i),
        .reg1_read_o(reg1_read_nf), .reg1_addr_o(reg1_addr_nf), .reg1_data_i(reg1_data_i),
        .reg2_read_o(reg2_read_nf), .reg2_addr_o(reg2_addr_nf), .reg2_data_i(reg2_data_i),
        .ex_wreg_i(ex_wreg_i), .ex_wd_i(ex_wd_i), .ex_wdata_i(ex_wdata_i), .ex_is_load_i(ex_is_load_i),
        .mem_wreg_i(mem_wreg_i), .mem_wd_i(mem_wd_i), .mem_wdata_i(mem_wdata_i),
        .stallreq_o(stallreq_nf), .out_valid(out_valid_nf), .out_ready(out_ready),
        .pc_o(pc_nf), .aluop_o(aluop_nf), .alusel_o(alusel_nf), .reg1_o(reg1_nf), .reg2_o(reg2_nf),
        .wd_o(wd_nf), .wreg_o(wreg_nf), .inst_invalid_o(inv_nf)
    );

    typedef struct {
        logic [31:0] pc;
        logic [7:0]  aluop;
        logic [2:0]  sel;
        logic [31:0] r1, r1nf, r2, r2nf;
        logic [4:0]  wd;
        logic        wreg, inv;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(logic [7:0] aluop, logic [2:0] sel, logic [31:0] r1, logic [31:0] r1nf,
                                logic [31:0] r2, logic [31:0] r2nf, logic [4:0] wd, logic wreg, logic inv);
        exp_t e;
        e.pc = '0; e.aluop = aluop; e.sel = sel; e.r1 = r1; e.r1nf = r1nf;
        e.r2 = r2; e.r2nf = r2nf; e.wd = wd; e.wreg = wreg; e.inv = inv;
        return e;
    endfunction

    // Monitor: an output handshake completes at the next rising edge
    always @(negedge clk) begin
        if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_output", 64'(pc_o), 64'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("pc",        64'(pc_o),           64'(e.pc));
                chk("aluop",     64'(aluop_o),        64'(e.aluop));
                chk("alusel",    64'(alusel_o),       64'(e.sel));
                chk("reg1",      64'(reg1_o),         64'(e.r1));
                chk("reg2",      64'(reg2_o),         64'(e.r2));
                chk("wd",        64'(wd_o),           64'(e.wd));
                chk("wreg",      64'(wreg_o),         64'(e.wreg));
                chk("invalid",   64'(inst_invalid_o), 64'(e.inv));
                chk("valid_nf",  64'(out_valid_nf),   64'd1);
                chk("reg1_nf",   64'(reg1_nf),        64'(e.r1nf));
                chk("reg2_nf",   64'(reg2_nf),        64'(e.r2nf));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one instruction, expect it to be accepted at the next edge
    task automatic send(input logic [31:0] inst, input logic [31:0] pc, input exp_t e);
        inst_i   = inst;
        pc_i     = pc;
        in_valid = 1'b1;
        e.pc     = pc;
        #1;
        chk("in_ready_send", 64'(in_ready), 64'd1);
        sb.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b1; flush_i = 1'b0; out_ready = 1'b1;
        pc_i = 32'h100; inst_i = 32'h3422_0F0F;
        reg1_data_i = 32'h1234_0000; reg2_data_i = 32'hDEAD_BEEF;
        ex_wreg_i = 1'b0; ex_wd_i = '0; ex_wdata_i = '0; ex_is_load_i = 1'b0;
        mem_wreg_i = 1'b0; mem_wd_i = '0; mem_wdata_i = '0;

        // Reset: everything zero, even with an instruction offered
        repeat (2) step();
        chk("rst_valid",  64'(out_valid),   64'd0);
        chk("rst_pc",     64'(pc_o),        64'd0);
        chk("rst_aluop",  64'(aluop_o),     64'd0);
        chk("rst_alusel", 64'(alusel_o),    64'd0);
        chk("rst_reg1",   64'(reg1_o),      64'd0);
        chk("rst_reg2",   64'(reg2_o),      64'd0);
        chk("rst_wd",     64'(wd_o),        64'd0);
        chk("rst_wreg",   64'(wreg_o),      64'd0);
        chk("rst_inv",    64'(inst_invalid_o), 64'd0);
        chk("rst_ready",  64'(in_ready),    64'd0);
        chk("rst_re1",    64'(reg1_read_o), 64'd0);
        chk("rst_addr1",  64'(reg1_addr_o), 64'd0);
        rst = 1'b0; in_valid = 1'b0;
        #1;
        chk("rel_ready", 64'(in_ready), 64'd1);
        step();
        chk("rel_valid", 64'(out_valid), 64'd0);

        // Basic ORI with combinational port checks
        inst_i = 32'h3422_0F0F;
        #1;
        chk("ori_re1",   64'(reg1_read_o), 64'd1);
        chk("ori_addr1", 64'(reg1_addr_o), 64'd1);
        chk("ori_re2",   64'(reg2_read_o), 64'd0);
        chk("ori_addr2", 64'(reg2_addr_o), 64'd2);
        send(32'h3422_0F0F, 32'h100, mk(8'h25, 3'd1, 32'h1234_0000, 32'h1234_0000, 32'h0F0F, 32'h0F0F, 5'd2, 1'b1, 1'b0));

        // Forwarding priority: EX over MEM, then MEM alone (back-to-back issue)
        ex_wreg_i = 1'b1; ex_wd_i = 5'd1; ex_wdata_i = 32'hAAAA_5555;
        mem_wreg_i = 1'b1; mem_wd_i = 5'd1; mem_wdata_i = 32'h1111_1111;
        send(32'h3422_0F0F, 32'h104, mk(8'h25, 3'd1, 32'hAAAA_5555, 32'h1234_0000, 32'h0F0F, 32'h0F0F, 5'd2, 1'b1, 1'b0));
        ex_wreg_i = 1'b0;
        send(32'h3422_0F0F, 32'h108, mk(8'h25, 3'd1, 32'h1111_1111, 32'h1234_0000, 32'h0F0F, 32'h0F0F, 5'd2, 1'b1, 1'b0));

        // AND $3,$1,$2: port1 from MEM, port2 from EX
        reg2_data_i = 32'hFFFF_0000;
        ex_wreg_i = 1'b1; ex_wd_i = 5'd2; ex_wdata_i = 32'h0F0F_0F0F;
        send(32'h0022_1824, 32'h10C, mk(8'h24, 3'd1, 32'h1111_1111, 32'h1234_0000, 32'h0F0F_0F0F, 32'hFFFF_0000, 5'd3, 1'b1, 1'b0));

        // SRA $4,$2,5: src1 = sa
        ex_wreg_i = 1'b0; mem_wreg_i = 1'b0;
        send(32'h0002_2143, 32'h110, mk(8'h03, 3'd2, 32'd5, 32'd5, 32'hFFFF_0000, 32'hFFFF_0000, 5'd4, 1'b1, 1'b0));

        // OR $5,$0,$2 with EX claiming to write $0: $0 still reads 0
        ex_wreg_i = 1'b1; ex_wd_i = 5'd0; ex_wdata_i = 32'h55;
        send(32'h0002_2825, 32'h114, mk(8'h25, 3'd1, 32'd0, 32'd0, 32'hFFFF_0000, 32'hFFFF_0000, 5'd5, 1'b1, 1'b0));

        // Load-use: load to unread rt does not stall, load to rs does
        inst_i = 32'h3422_0F0F; pc_i = 32'h118; in_valid = 1'b1;
        ex_is_load_i = 1'b1; ex_wreg_i = 1'b1; ex_wd_i = 5'd2;
        #1;
        chk("nostall_rt", 64'(stallreq_o), 64'd0);
        ex_wd_i = 5'd1;
        #1;
        chk("stall_req",   64'(stallreq_o), 64'd1);
        chk("stall_ready", 64'(in_ready),   64'd0);
        step();
        chk("stall_bubble", 64'(out_valid), 64'd0);
        chk("stall_hold",   64'(stallreq_o), 64'd1);
        ex_is_load_i = 1'b0; ex_wreg_i = 1'b0;
        send(32'h3422_0F0F, 32'h118, mk(8'h25, 3'd1, 32'h1234_0000, 32'h1234_0000, 32'h0F0F, 32'h0F0F, 5'd2, 1'b1, 1'b0));
        chk("unstall_valid", 64'(out_valid), 64'd1);
        repeat (2) step();

        // Backpressure: XORI held for 3 cycles while another instruction waits
        out_ready = 1'b0;
        inst_i = 32'h3843_1234; pc_i = 32'h200; in_valid = 1'b1;
        step();
        inst_i = 32'h3422_0F0F; pc_i = 32'h204; reg1_data_i = 32'h9999_9999;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_valid", 64'(out_valid), 64'd1);
            chk("bp_ready", 64'(in_ready),  64'd0);
            chk("bp_pc",    64'(pc_o),      64'h200);
            chk("bp_aluop", 64'(aluop_o),   64'h26);
            chk("bp_reg1",  64'(reg1_o),    64'h1234_0000);
            chk("bp_reg2",  64'(reg2_o),    64'h1234);
            chk("bp_wd",    64'(wd_o),      64'd3);
            step();
        end
        flush_i = 1'b1;
        step();
        chk("flush_valid", 64'(out_valid), 64'd0);
        flush_i = 1'b0; in_valid = 1'b0; out_ready = 1'b1; reg1_data_i = 32'h1234_0000;
        step();
        chk("flush_stays_empty", 64'(out_valid), 64'd0);

        // LUI, an invalid opcode, and the all-zero word
        send(32'h3C01_ABCD, 32'h300, mk(8'h25, 3'd1, 32'd0, 32'd0, 32'hABCD_0000, 32'hABCD_0000, 5'd1, 1'b1, 1'b0));
        send(32'hFC00_0000, 32'h304, mk(8'h00, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1));
        send(32'h0000_0000, 32'h308, mk(8'h7C, 3'd2, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b1, 1'b0));

        for (int i = 0; i < 20 && sb.size() > 0; i++) step();
        step();
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
